// File: rtl/demux_collector_if.sv
// Handshake bundle for demux_collector: beat input side, assembled-word output side
// and the sticky duplicate-write flag.
interface demux_collector_if #(
  parameter int NR_LANE  = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 1
);
  logic                         sel_mode;
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_LEN-1:0]          in_data;
  logic [SEL_LEN-1:0]           in_sel;
  logic [NR_LANE*DATA_LEN-1:0]  lane_out;
  logic [NR_LANE*DATA_LEN-1:0]  word;
  logic                         word_valid;
  logic                         word_ready;
  logic                         dup_err;

  modport master (
    output sel_mode, in_valid, in_data, in_sel, word_ready,
    input  in_ready, lane_out, word, word_valid, dup_err
  );

  modport slave (
    input  sel_mode, in_valid, in_data, in_sel, word_ready,
    output in_ready, lane_out, word, word_valid, dup_err
  );
endinterface

// File: rtl/demux_collector.sv
// Demultiplexes a serial lane stream back into a parallel word, addressing lanes from
// an internal counter (auto) or an explicit select, with a one-deep output register.
module demux_collector #(
  parameter int NR_LANE  = 4,
  parameter int SEL_LEN  = 2,
  parameter int DATA_LEN = 1
) (
  input logic             clk,
  input logic             rst_n,
  demux_collector_if.slave bus
);
  localparam int WORD_LEN = NR_LANE * DATA_LEN;

  function automatic logic [NR_LANE-1:0] lane_onehot(input logic [SEL_LEN-1:0] lane);
    lane_onehot = {{(NR_LANE-1){1'b0}}, 1'b1} << lane;
  endfunction

  logic                  mode_r;
  logic [SEL_LEN-1:0]    cnt_r;
  logic [NR_LANE-1:0]    mask_r;
  logic [WORD_LEN-1:0]   shadow_r;
  logic [WORD_LEN-1:0]   lane_out_r;
  logic [WORD_LEN-1:0]   word_r;
  logic                  word_valid_r;
  logic                  dup_err_r;

  logic [SEL_LEN-1:0]    lane_s;
  logic [NR_LANE-1:0]    lane_bit_s;
  logic [NR_LANE-1:0]    mask_next_s;
  logic                  partial_s;
  logic                  discard_s;
  logic                  would_complete_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic [WORD_LEN-1:0]   merged_s;
  logic [WORD_LEN-1:0]   beat_view_s;

  // Lane decode, completion prediction, backpressure and the merged/demuxed beat views.
  always_comb begin
    lane_s           = cnt_r;
    merged_s         = shadow_r;
    beat_view_s      = {WORD_LEN{1'b0}};
    would_complete_s = 1'b0;
    in_ready_s       = 1'b0;

    if (bus.sel_mode) begin
      lane_s = bus.in_sel;
    end else begin
      lane_s = cnt_r;
    end

    lane_bit_s  = lane_onehot(lane_s);
    mask_next_s = mask_r | lane_bit_s;
    partial_s   = (cnt_r != {SEL_LEN{1'b0}}) || (mask_r != {NR_LANE{1'b0}});
    // A mode flip mid-word throws away the partial word, including this cycle's beat.
    discard_s   = (bus.sel_mode != mode_r) && partial_s;

    if (discard_s) begin
      would_complete_s = 1'b0;
    end else if (bus.sel_mode) begin
      would_complete_s = &mask_next_s;
    end else begin
      would_complete_s = (cnt_r == SEL_LEN'(NR_LANE - 1));
    end

    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !(would_complete_s && word_valid_r && !bus.word_ready);
    end

    accept_s = bus.in_valid && in_ready_s && !discard_s;

    for (int n = 0; n < NR_LANE; n++) begin
      if (lane_s == SEL_LEN'(n)) begin
        merged_s[n*DATA_LEN +: DATA_LEN]    = bus.in_data;
        beat_view_s[n*DATA_LEN +: DATA_LEN] = bus.in_data;
      end else begin
        merged_s[n*DATA_LEN +: DATA_LEN]    = shadow_r[n*DATA_LEN +: DATA_LEN];
        beat_view_s[n*DATA_LEN +: DATA_LEN] = {DATA_LEN{1'b0}};
      end
    end
  end

  // Collection state, output word register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r       <= 1'b0;
      cnt_r        <= {SEL_LEN{1'b0}};
      mask_r       <= {NR_LANE{1'b0}};
      shadow_r     <= {WORD_LEN{1'b0}};
      lane_out_r   <= {WORD_LEN{1'b0}};
      word_r       <= {WORD_LEN{1'b0}};
      word_valid_r <= 1'b0;
      dup_err_r    <= 1'b0;
    end else begin
      mode_r <= bus.sel_mode;

      if (discard_s) begin
        cnt_r  <= {SEL_LEN{1'b0}};
        mask_r <= {NR_LANE{1'b0}};
      end else if (accept_s) begin
        shadow_r   <= merged_s;
        lane_out_r <= beat_view_s;
        if (bus.sel_mode) begin
          if ((mask_r & lane_bit_s) != {NR_LANE{1'b0}}) begin
            dup_err_r <= 1'b1;
          end else begin
            dup_err_r <= dup_err_r;
          end
          if (would_complete_s) begin
            mask_r <= {NR_LANE{1'b0}};
          end else begin
            mask_r <= mask_next_s;
          end
        end else begin
          cnt_r <= cnt_r + {{(SEL_LEN-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r  <= cnt_r;
        mask_r <= mask_r;
      end

      // A completion on the consuming edge keeps word_valid high with the new word.
      if (accept_s && would_complete_s) begin
        word_r       <= merged_s;
        word_valid_r <= 1'b1;
      end else if (bus.word_ready) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.lane_out   = lane_out_r;
  assign bus.word       = word_r;
  assign bus.word_valid = word_valid_r;
  assign bus.dup_err    = dup_err_r;
endmodule

// File: tb/tb_demux_collector.sv
// Self-checking bench for demux_collector: directed scenarios plus a randomized run,
// all compared against a lane-array reference model.
module tb_demux_collector;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_collector_if #(.NR_LANE(4), .SEL_LEN(2), .DATA_LEN(1)) bus ();
  demux_collector #(.NR_LANE(4), .SEL_LEN(2), .DATA_LEN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-lane data, lane counter, set of filled lanes.
  bit         m_data[4];
  bit         m_filled[4];
  int         m_cnt;
  bit         m_mode;
  logic [3:0] m_word;
  logic [3:0] m_lane_out;
  bit         m_wv;
  bit         m_dup;
  bit         exp_ready, obs_ready, last_acc;
  int         n_acc, n_words;
  logic [10:0] obs_vec, exp_vec;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 1'b0;
      m_filled[i] = 1'b0;
    end
    m_cnt = 0; m_mode = 1'b0; m_word = 4'b0000; m_lane_out = 4'b0000;
    m_wv = 1'b0; m_dup = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, capture observed/expected vectors.
  task automatic drive_cycle(input bit rn, input bit sm, input bit iv, input bit d,
                             input int s, input bit wr);
    bit partial, discard, completes;
    int lane, nfill;
    rst_n = rn; bus.sel_mode = sm; bus.in_valid = iv; bus.in_data = d;
    bus.in_sel = 2'(s); bus.word_ready = wr;
    #1;
    obs_ready = bus.in_ready;
    partial = (m_cnt != 0);
    for (int i = 0; i < 4; i++) if (m_filled[i]) partial = 1'b1;
    discard = (sm != m_mode) && partial;
    lane = sm ? s : m_cnt;
    nfill = 0;
    for (int i = 0; i < 4; i++) if (m_filled[i] || i == lane) nfill++;
    completes = !discard && (sm ? (nfill == 4) : (m_cnt == 3));
    exp_ready = rn && !(completes && m_wv && !wr);
    last_acc = rn && iv && exp_ready && !discard;
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
      last_acc = 1'b0;
    end else begin
      m_mode = sm;
      if (discard) begin
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_filled[i] = 1'b0;
      end else if (last_acc) begin
        m_data[lane] = d;
        m_lane_out = d ? (4'b0001 << lane) : 4'b0000;
        if (sm) begin
          if (m_filled[lane]) m_dup = 1'b1;
          m_filled[lane] = 1'b1;
          if (completes) for (int i = 0; i < 4; i++) m_filled[i] = 1'b0;
        end else begin
          m_cnt = (m_cnt + 1) % 4;
        end
        n_acc++;
      end
      if (last_acc && completes) begin
        for (int i = 0; i < 4; i++) m_word[i] = m_data[i];
        m_wv = 1'b1;
        n_words++;
      end else if (wr) begin
        m_wv = 1'b0;
      end
    end
    obs_vec = {obs_ready, bus.lane_out, bus.word, bus.word_valid, bus.dup_err};
    exp_vec = {exp_ready, m_lane_out, m_word, m_wv, m_dup};
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b1);
      vectors++;
      if (obs_vec !== 11'b0 || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset: got rdy,lane,word,wv,dup=%b want %b", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_auto_basic();
    bit         d_seq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] lo_exp[4] = '{4'b0001, 4'b0000, 4'b0100, 4'b1000};
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, d_seq[c], 0, 1'b1);
      vectors++;
      if (obs_vec !== exp_vec || bus.lane_out !== lo_exp[c]) begin
        miscompares++;
        $display("FAIL auto_basic beat %0d: got %b want %b (lane_out want %b)",
                 c, obs_vec, exp_vec, lo_exp[c]);
      end
    end
    vectors++;
    if (bus.word !== 4'b1101 || bus.word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_basic word: got %b/%b want 1101/1", bus.word, bus.word_valid);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec || bus.word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL auto_basic pulse: got %b want %b", obs_vec, exp_vec);
    end
  endtask

  task automatic test_backpressure();
    bit seq[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int idx = 0;
    int stall = 0;
    for (int c = 0; c < 20 && idx < 8 && stall < 2; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, seq[idx], 0, 1'b0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: got %b want %b", c, obs_vec, exp_vec);
      end
      if (last_acc) idx++;
      else stall++;
    end
    vectors++;
    if (idx !== 7 || obs_ready !== 1'b0 || bus.word !== 4'b1111 || bus.word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure hold: accepted=%0d rdy=%b word=%b wv=%b want 7/0/1111/1",
               idx, obs_ready, bus.word, bus.word_valid);
    end
    drive_cycle(1'b1, 1'b0, 1'b1, seq[7], 0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec || obs_ready !== 1'b1 || bus.word !== 4'b0000 || bus.word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure release: got %b want %b (word want 0000)", obs_vec, exp_vec);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL backpressure drain: got %b want %b", obs_vec, exp_vec);
    end
  endtask

  task automatic test_explicit();
    int sel_seq[4] = '{3, 0, 2, 1};
    bit d_seq[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, d_seq[c], sel_seq[c], 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL explicit beat %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (bus.word !== 4'b1010 || bus.word_valid !== 1'b1 || bus.dup_err !== 1'b0) begin
      miscompares++;
      $display("FAIL explicit word: got %b/%b/%b want 1010/1/0", bus.word, bus.word_valid, bus.dup_err);
    end
  endtask

  task automatic test_dup();
    int sel_seq[5] = '{0, 0, 1, 2, 3};
    bit d_seq[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, d_seq[c], sel_seq[c], 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL dup beat %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (bus.word !== 4'b1110 || bus.dup_err !== 1'b1) begin
      miscompares++;
      $display("FAIL dup word: got word=%b dup=%b want 1110/1", bus.word, bus.dup_err);
    end
  endtask

  task automatic test_mode_switch();
    int wv_cycles = 0;
    int words_before;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    words_before = n_words;
    // Switch edge carries a beat that must be dropped.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec || bus.word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mode_switch discard: got %b want %b", obs_vec, exp_vec);
    end
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, c, 1'b1);
      if (bus.word_valid === 1'b1) wv_cycles++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL mode_switch beat %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (bus.word !== 4'b0000 || wv_cycles !== 1 || n_words - words_before !== 1) begin
      miscompares++;
      $display("FAIL mode_switch word: got word=%b wv_cycles=%0d want 0000/1", bus.word, wv_cycles);
    end
  endtask

  task automatic test_reset_mid();
    bit d_fill[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit d_new[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, d_fill[c], 0, 1'b0);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_mid fill %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    vectors++;
    if (obs_vec !== 11'b0 || obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL reset_mid clear: got %b want all zero", obs_vec);
    end
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, d_new[c], 0, 1'b1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_mid beat %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (bus.word !== 4'b0010 || bus.word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid word: got %b/%b want 0010/1", bus.word, bus.word_valid);
    end
  endtask

  task automatic test_random();
    bit sm = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) sm = !sm;
      drive_cycle(($urandom_range(0, 99) != 0), sm, 1'($urandom_range(0, 3) != 0),
                  1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0));
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b want %b", c, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.sel_mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = 1'b0;
    bus.in_sel = 2'd0; bus.word_ready = 1'b0;
    n_acc = 0; n_words = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_auto_basic();
    test_backpressure();
    test_explicit();
    test_dup();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
